// File: rtl/hamming_secded_checker.sv
// Registered SECDED checker for a 22-bit extended Hamming codeword (16 data, 5 parity, 1 overall parity).
// Classifies each accepted word, reports its syndrome, corrects single errors and extracts the payload.
module hamming_secded_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [21:0] data,
  output logic        out_valid,
  output logic [1:0]  error_code,
  output logic [4:0]  syndrome,
  output logic [21:0] corrected,
  output logic [15:0] data_out
);

  logic [4:0]  syn_c;
  logic        op_c;
  logic [21:0] flip_c;
  logic [1:0]  code_c;
  logic [21:0] corr_c;
  logic [15:0] pay_c;

  always_comb begin
    syn_c = '0;
    for (int unsigned p = 1; p < 22; p++) begin
      if (data[p-1]) syn_c = syn_c ^ 5'(p);
    end
    op_c = ^data;

    // One-hot flip mask for an in-range syndrome; empty for 22..31.
    flip_c = '0;
    for (int unsigned p = 1; p < 22; p++) begin
      if (syn_c == 5'(p)) flip_c[p-1] = 1'b1;
    end

    code_c = 2'b11;
    corr_c = data;
    if (syn_c == '0) begin
      if (op_c) begin
        code_c = 2'b01;
        corr_c = data ^ 22'h200000;
      end else begin
        code_c = 2'b00;
      end
    end else if (op_c && (flip_c != '0)) begin
      code_c = 2'b10;
      corr_c = data ^ flip_c;
    end

    pay_c = {corr_c[20], corr_c[19], corr_c[18], corr_c[17], corr_c[16],
             corr_c[14], corr_c[13], corr_c[12], corr_c[11], corr_c[10],
             corr_c[9],  corr_c[8],  corr_c[6],  corr_c[5],  corr_c[4],
             corr_c[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      error_code <= '0;
      syndrome   <= '0;
      corrected  <= '0;
      data_out   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        error_code <= code_c;
        syndrome   <= syn_c;
        corrected  <= corr_c;
        data_out   <= pay_c;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_checker.sv
// Directed plus randomized bench for hamming_secded_checker; random words come from an encoder with known error injection.
module tb_hamming_secded_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [21:0] data;
  logic        out_valid;
  logic [1:0]  error_code;
  logic [4:0]  syndrome;
  logic [21:0] corrected;
  logic [15:0] data_out;

  int vectors = 0;
  int miscompares = 0;
  int checks = 0;

  logic        ev;
  logic [1:0]  ec;
  logic [4:0]  es;
  logic [21:0] ek;

  always #5 clk = ~clk;

  hamming_secded_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .data       (data),
    .out_valid  (out_valid),
    .error_code (error_code),
    .syndrome   (syndrome),
    .corrected  (corrected),
    .data_out   (data_out)
  );

  // Syndrome as the XOR of the integer positions of all set bits (bit 21 has no position).
  function automatic logic [4:0] pos_xor(input logic [21:0] w);
    int acc = 0;
    for (int p = 1; p <= 21; p++) if (w[p-1]) acc = acc ^ p;
    return acc[4:0];
  endfunction

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [15:0] payload(input logic [21:0] w);
    logic [15:0] d = '0;
    int j = 0;
    for (int p = 1; p <= 21; p++) begin
      if (!is_pow2(p)) begin
        d[j] = w[p-1];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [21:0] encode(input logic [15:0] d);
    logic [21:0] w = '0;
    logic [4:0]  s;
    int j = 0;
    for (int p = 1; p <= 21; p++) begin
      if (!is_pow2(p)) begin
        w[p-1] = d[j];
        j++;
      end
    end
    s = pos_xor(w);
    for (int k = 0; k < 5; k++) w[(1 << k) - 1] = s[k];
    w[21] = ^w[20:0];
    return w;
  endfunction

  // Classification of an arbitrary received word straight from the decision table.
  task automatic classify(input logic [21:0] w, output logic [1:0] c, output logic [4:0] s,
                          output logic [21:0] k);
    int si;
    logic op;
    s  = pos_xor(w);
    si = int'(s);
    op = ^w;
    k  = w;
    if (si == 0 && !op) c = 2'b00;
    else if (si == 0) begin c = 2'b01; k[21] = ~w[21]; end
    else if (si <= 21 && op) begin c = 2'b10; k[si-1] = ~w[si-1]; end
    else c = 2'b11;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [21:0] d, input logic [1:0] c,
                      input logic [4:0] s, input logic [21:0] k, input string tag);
    rst = r; in_valid = v; data = d;
    @(posedge clk);
    #1;
    if (r) begin
      ev = 1'b0; ec = '0; es = '0; ek = '0;
    end else if (v) begin
      ev = 1'b1; ec = c; es = s; ek = k;
    end else begin
      ev = 1'b0;
    end
    vectors++;
    chk({tag, ".out_valid"},  32'(out_valid),  32'(ev));
    chk({tag, ".error_code"}, 32'(error_code), 32'(ec));
    chk({tag, ".syndrome"},   32'(syndrome),   32'(es));
    chk({tag, ".corrected"},  32'(corrected),  32'(ek));
    chk({tag, ".data_out"},   32'(data_out),   32'(payload(ek)));
  endtask

  localparam logic [21:0] CLEAN = 22'b0100010000001100001100;
  localparam logic [21:0] SERR2 = 22'b0100010000001100001110;
  localparam logic [21:0] PERR  = 22'b1100010000001100001100;
  localparam logic [21:0] DERR  = 22'b0100010000001100001010;

  initial begin
    logic [21:0] cw, w;
    logic [1:0]  c;
    logic [4:0]  s;
    logic [21:0] k;
    int mode, a, b, pa, pb;

    ev = 1'b0; ec = '0; es = '0; ek = '0;

    step(1'b1, 1'b1, CLEAN, 2'b00, 5'd0, CLEAN, "reset0");
    step(1'b1, 1'b1, CLEAN, 2'b00, 5'd0, CLEAN, "reset1");
    chk("clean.payload_const", 32'(payload(CLEAN)), 32'h8831);

    step(1'b0, 1'b1, CLEAN, 2'b00, 5'd0,  CLEAN, "clean");
    step(1'b0, 1'b1, SERR2, 2'b10, 5'd2,  CLEAN, "single_pos2");
    step(1'b0, 1'b1, PERR,  2'b01, 5'd0,  CLEAN, "overall_bit");
    step(1'b0, 1'b1, DERR,  2'b11, 5'd1,  DERR,  "double_2_3");
    step(1'b0, 1'b1, 22'h3FFFFF, 2'b11, 5'd1, 22'h3FFFFF, "all_ones");

    step(1'b0, 1'b1, CLEAN, 2'b00, 5'd0, CLEAN, "stream0");
    step(1'b0, 1'b1, SERR2, 2'b10, 5'd2, CLEAN, "stream1");
    step(1'b0, 1'b1, PERR,  2'b01, 5'd0, CLEAN, "stream2");
    step(1'b0, 1'b0, 22'h155555, 2'b00, 5'd0, 22'h0, "idle_hold0");
    step(1'b0, 1'b0, 22'h2AAAAA, 2'b00, 5'd0, 22'h0, "idle_hold1");

    step(1'b0, 1'b1, SERR2, 2'b10, 5'd2, CLEAN, "pre_rst");
    step(1'b1, 1'b1, DERR,  2'b11, 5'd1, DERR,  "rst_mid");
    step(1'b0, 1'b0, DERR,  2'b11, 5'd1, DERR,  "after_rst_idle");

    for (int i = 0; i < 400; i++) begin
      cw   = encode(16'($urandom));
      mode = int'($urandom_range(0, 5));
      w    = cw;
      k    = cw;
      c    = 2'b00;
      s    = 5'd0;
      case (mode)
        1: begin
          a = int'($urandom_range(0, 20));
          w[a] = ~w[a];
          c = 2'b10; s = 5'(a + 1);
        end
        2: begin
          w[21] = ~w[21];
          c = 2'b01;
        end
        3: begin
          a = int'($urandom_range(0, 21));
          b = int'($urandom_range(0, 20));
          if (b >= a) b++;
          w[a] = ~w[a];
          w[b] = ~w[b];
          pa = (a == 21) ? 0 : a + 1;
          pb = (b == 21) ? 0 : b + 1;
          c = 2'b11; s = 5'(pa ^ pb); k = w;
        end
        4: begin
          w = 22'($urandom);
          classify(w, c, s, k);
        end
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, w, c, s, k, "rand_idle");
      else step(1'b0, 1'b1, w, c, s, k, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hamming_secded_checker.md
Name: hamming_secded_checker

Overview:
- Registered SECDED (single-error-correct, double-error-detect) checker for a 22-bit extended Hamming codeword.
- The codeword carries 16 data bits, 5 Hamming parity bits and 1 overall even-parity bit.
- Each accepted word is classified, its syndrome is reported, single-bit errors are corrected, and the 16 data bits are extracted.
- Sits on the receive side of a protected link or memory read path, after the raw codeword register.

Parameters:
- None. All widths are fixed: codeword 22, syndrome 5, data payload 16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data is a new codeword this cycle.
- data  input  22  received codeword.
- out_valid  output  1  registered; high for one cycle per accepted word.
- error_code  output  2  00 no error, 01 overall-parity-bit error, 10 single correctable error, 11 uncorrectable (double) error.
- syndrome  output  5  computed Hamming syndrome.
- corrected  output  22  codeword after correction.
- data_out  output  16  payload extracted from corrected.

Behaviour:
- Codeword layout:
  - Hamming position p (1..21) is data[p-1].
  - Parity bits sit at positions 1, 2, 4, 8, 16.
  - data[21] is the overall parity bit. The whole 22-bit word has even parity when error-free.
- Syndrome: s[k] = XOR of data[p-1] over all p in 1..21 whose bit k is set, for k = 0..4.
- Overall check: op = XOR of data[21:0].
- Classification:
  - s==0, op==0 -> 00. corrected = data.
  - s==0, op==1 -> 01. corrected = data with data[21] inverted.
  - s in 1..21, op==1 -> 10. corrected = data with data[s-1] inverted.
  - s!=0, op==0 -> 11. corrected = data unchanged.
  - s in 22..31, op==1 (impossible single error) -> 11. corrected = data unchanged.
- Payload extraction: data_out[15:0], LSB first, takes corrected at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21.
- Latency: 1 cycle.
  - A word presented with in_valid=1 at edge N appears on all outputs after edge N, with out_valid=1.
- Pipeline behaviour:
  - Back-to-back words are accepted every cycle; there is no backpressure.
  - in_valid=0 -> out_valid=0 next cycle; error_code, syndrome, corrected and data_out hold their previous values.
- Reset:
  - rst=1 at an edge clears out_valid, error_code (00), syndrome (0), corrected (0) and data_out (0).
  - Reset has priority over in_valid. A word presented in the same cycle as rst is discarded.
- Datapath is purely combinational from data into the output registers. No multicycle paths, no X propagation from the idle input.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, error_code=00, syndrome=0, corrected=0, data_out=0. First word after rst deasserts appears 1 cycle later.
- Clean word: data=22'b0100010000001100001100 -> error_code=00, syndrome=0, corrected=same, data_out=16'h8831.
- Single error at position 2: data=22'b0100010000001100001110 -> error_code=10, syndrome=2, corrected=22'b0100010000001100001100, data_out=16'h8831.
- Overall parity bit error: data=22'b1100010000001100001100 -> error_code=01, syndrome=0, corrected=22'b0100010000001100001100.
- Double errors:
  - data=22'b0100010000001100001010 (positions 2 and 3 flipped) -> error_code=11, syndrome=1, corrected=input unchanged.
  - data=22'h3FFFFF -> error_code=11, syndrome=1.
- Handshake: stream the clean, single-error and parity-error words back-to-back, then drop in_valid -> three consecutive out_valid pulses with matching codes 00, 10, 01. out_valid=0 afterwards with outputs held. Assert rst mid-stream -> the word in flight is lost.
